// File: rtl/pixel_row_readout_pkg.sv
// Shared definitions for the pixel-array blocks: default geometry and the
// frame sequencer state encoding.
package pixel_row_readout_pkg;

  localparam int DEF_WIDTH        = 4;
  localparam int DEF_BITS         = 8;
  localparam int DEF_ERASE_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READOUT
  } state_e;

endpackage

// File: rtl/pixel_row_readout_column_latch.sv
// First-crossing latch for one pixel column: captures the ramp count on the
// first comparator hit of a conversion and reports full scale if none occurs.
module column_latch
  import pixel_row_readout_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic            cmp_i,
  input  logic [BITS-1:0] count_i,
  output logic [BITS-1:0] value_o
);

  logic            hit_q;
  logic [BITS-1:0] val_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q <= 1'b0;
      val_q <= '0;
    end else if (clear_i) begin
      hit_q <= 1'b0;
      val_q <= '0;
    end else if (en_i && cmp_i && !hit_q) begin
      hit_q <= 1'b1;
      val_q <= count_i;
    end
  end

  // A column that never crossed reads as the top of the ramp.
  assign value_o = hit_q ? val_q : '1;

endmodule

// File: rtl/pixel_row_readout.sv
// Row capture sequencer: erase, expose, ramp-convert all columns in parallel,
// then stream the row (optionally 2:1 binned) over a valid/ready channel.
module pixel_row_readout
  import pixel_row_readout_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int BITS         = DEF_BITS,
  parameter int ERASE_CYCLES = DEF_ERASE_CYCLES
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             BIN2,
  input  logic [15:0]      EXPOSE_CYCLES,
  input  logic [WIDTH-1:0] CMP,
  output logic             PIX_ERASE,
  output logic             PIX_EXPOSE,
  output logic             PIX_READ,
  output logic [BITS-1:0]  COUNTER,
  output logic [BITS-1:0]  DATA_OUT,
  output logic             VALID,
  input  logic             READY,
  output logic             LAST,
  output logic             BUSY,
  output logic             DONE
);

  localparam int          IDX_W      = $clog2(WIDTH) + 1;
  localparam logic [15:0] ERASE_LOAD = 16'(ERASE_CYCLES - 1);

  state_e            state_q;
  logic              bin2_q;
  logic [15:0]       expose_q;
  logic [15:0]       phase_q;
  logic [BITS-1:0]   counter_q;
  logic [IDX_W-1:0]  beat_q;
  logic [BITS-1:0]   data_q;
  logic              valid_q, last_q;
  logic              erase_q, expose_en_q, read_q, busy_q, done_q;

  logic [BITS-1:0]   col_val  [WIDTH];
  logic [BITS-1:0]   pair_avg [WIDTH/2];
  logic [IDX_W-1:0]  beat_sel_d;
  logic [IDX_W-1:0]  n_beats_d;
  logic [BITS-1:0]   beat_data_d;
  logic              beat_last_d;
  logic              latch_clear_d;
  logic              latch_en_d;

  assign latch_clear_d = (state_q == ST_IDLE) && START;
  assign latch_en_d    = (state_q == ST_CONVERT);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_col
      column_latch #(.BITS(BITS)) u_latch (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .clear_i (latch_clear_d),
        .en_i    (latch_en_d),
        .cmp_i   (CMP[gi]),
        .count_i (counter_q),
        .value_o (col_val[gi])
      );
    end
    // Pair sum is formed one bit wider so the average never wraps.
    for (gi = 0; gi < WIDTH/2; gi++) begin : g_pair
      assign pair_avg[gi] = BITS'(({1'b0, col_val[2*gi]} + {1'b0, col_val[2*gi+1]}) >> 1);
    end
  endgenerate

  // The beat prepared next: beat 0 while leaving CONVERT, else the successor.
  assign beat_sel_d  = (state_q == ST_CONVERT) ? '0 : beat_q + IDX_W'(1);
  assign n_beats_d   = bin2_q ? IDX_W'(WIDTH/2) : IDX_W'(WIDTH);
  assign beat_last_d = (beat_sel_d == n_beats_d - IDX_W'(1));

  always_comb begin
    beat_data_d = '0;
    for (int k = 0; k < WIDTH; k++)
      if (!bin2_q && beat_sel_d == IDX_W'(k)) beat_data_d = col_val[k];
    for (int k = 0; k < WIDTH/2; k++)
      if (bin2_q && beat_sel_d == IDX_W'(k)) beat_data_d = pair_avg[k];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      bin2_q      <= 1'b0;
      expose_q    <= '0;
      phase_q     <= '0;
      counter_q   <= '0;
      beat_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      erase_q     <= 1'b0;
      expose_en_q <= 1'b0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            bin2_q   <= BIN2;
            expose_q <= (EXPOSE_CYCLES == 16'd0) ? 16'd1 : EXPOSE_CYCLES;
            phase_q  <= ERASE_LOAD;
            erase_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_ERASE;
          end
        end
        ST_ERASE: begin
          if (phase_q == 16'd0) begin
            erase_q     <= 1'b0;
            expose_en_q <= 1'b1;
            phase_q     <= expose_q - 16'd1;
            state_q     <= ST_EXPOSE;
          end else begin
            phase_q <= phase_q - 16'd1;
          end
        end
        ST_EXPOSE: begin
          if (phase_q == 16'd0) begin
            expose_en_q <= 1'b0;
            read_q      <= 1'b1;
            counter_q   <= '0;
            state_q     <= ST_CONVERT;
          end else begin
            phase_q <= phase_q - 16'd1;
          end
        end
        ST_CONVERT: begin
          if (counter_q == '1) begin
            read_q    <= 1'b0;
            counter_q <= '0;
            valid_q   <= 1'b1;
            beat_q    <= '0;
            data_q    <= beat_data_d;
            last_q    <= beat_last_d;
            state_q   <= ST_READOUT;
          end else begin
            counter_q <= counter_q + 1'b1;
          end
        end
        ST_READOUT: begin
          if (valid_q && READY) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              data_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              beat_q <= beat_sel_d;
              data_q <= beat_data_d;
              last_q <= beat_last_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PIX_ERASE  = erase_q;
  assign PIX_EXPOSE = expose_en_q;
  assign PIX_READ   = read_q;
  assign COUNTER    = counter_q;
  assign DATA_OUT   = data_q;
  assign VALID      = valid_q;
  assign LAST       = last_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_pixel_row_readout.sv
// Bench for pixel_row_readout: scripted and randomized frames checked against
// a column-crossing reference model of the row.
module tb_pixel_row_readout;

  localparam int W  = 4;
  localparam int B  = 4;
  localparam int EC = 4;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          START = 1'b0;
  logic          BIN2 = 1'b0;
  logic [15:0]   EXPOSE_CYCLES = '0;
  logic [W-1:0]  CMP = '0;
  logic          READY = 1'b0;
  logic          PIX_ERASE, PIX_EXPOSE, PIX_READ, VALID, LAST, BUSY, DONE;
  logic [B-1:0]  COUNTER, DATA_OUT;

  pixel_row_readout #(.WIDTH(W), .BITS(B), .ERASE_CYCLES(EC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .BIN2(BIN2),
    .EXPOSE_CYCLES(EXPOSE_CYCLES), .CMP(CMP), .PIX_ERASE(PIX_ERASE),
    .PIX_EXPOSE(PIX_EXPOSE), .PIX_READ(PIX_READ), .COUNTER(COUNTER),
    .DATA_OUT(DATA_OUT), .VALID(VALID), .READY(READY), .LAST(LAST),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  // Stimulus knobs: rise[i] = conversion cycle where column i first crosses (>15 = never)
  int rise [W];
  bit glitch;
  int ready_mode;   // 0 always ready, 1 random, 2 five-cycle stall at beat 1
  bit busy_start;
  bit chain;
  bit chain_bin2;
  logic [15:0] chain_exp;

  // Observations of the last frame
  int erase_cnt, expose_cnt, read_cnt, counter_bad, hold_bad, done_cnt;
  int done_delay_bad, busy_done_bad, valid_late, busy_after, stall_used;
  bit timeout;
  logic [B-1:0] got_data [$];
  bit           got_last [$];
  logic [B-1:0] exp_data [$];

  // Reference: a column reads its first-crossing cycle, or full scale.
  function automatic int col_value(int i);
    return (rise[i] < (1 << B)) ? rise[i] : (1 << B) - 1;
  endfunction

  task automatic build_model(input bit bin2);
    exp_data.delete();
    if (bin2) for (int k = 0; k < W/2; k++) exp_data.push_back(B'((col_value(2*k) + col_value(2*k+1)) / 2));
    else      for (int k = 0; k < W; k++)   exp_data.push_back(B'(col_value(k)));
  endtask

  task automatic run_frame(input bit bin2, input logic [15:0] expo, input bit skip_start);
    int  conv_cyc, post;
    bit  fin, prev_read, prev_stall, prev_xfer_last, prev_last, xfer;
    logic [B-1:0] prev_data;
    erase_cnt = 0; expose_cnt = 0; read_cnt = 0; counter_bad = 0; hold_bad = 0;
    done_cnt = 0; done_delay_bad = 0; busy_done_bad = 0; valid_late = 0;
    busy_after = 0; stall_used = 0; timeout = 0;
    got_data.delete(); got_last.delete();
    conv_cyc = 0; post = -1; fin = 0;
    prev_read = 0; prev_stall = 0; prev_xfer_last = 0; prev_last = 0; prev_data = '0;
    if (!skip_start) begin
      @(negedge CLK);
      START = 1'b1; BIN2 = bin2; EXPOSE_CYCLES = expo;
    end
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge CLK);
      START = 1'b0;
      if (cyc == 0) begin BIN2 = 1'($urandom); EXPOSE_CYCLES = 16'($urandom); end
      if (PIX_ERASE)  erase_cnt++;
      if (PIX_EXPOSE) expose_cnt++;
      if (PIX_READ) begin
        read_cnt++;
        if (COUNTER !== B'(conv_cyc)) counter_bad++;
      end else if (COUNTER !== '0) counter_bad++;
      if (prev_read && !PIX_READ && VALID !== 1'b1) valid_late++;
      if (prev_stall && (VALID !== 1'b1 || DATA_OUT !== prev_data || LAST !== prev_last)) hold_bad++;
      if (prev_xfer_last) begin
        if (DONE !== 1'b1) done_delay_bad++;
        if (BUSY !== 1'b0) busy_done_bad++;
      end
      if (DONE === 1'b1) done_cnt++;
      if (post >= 0 && BUSY === 1'b1) busy_after++;
      case (ready_mode)
        1:       READY = 1'($urandom);
        2:       begin
                   READY = !(VALID && got_data.size() == 1 && stall_used < 5);
                   if (!READY) stall_used++;
                 end
        default: READY = 1'b1;
      endcase
      xfer = VALID && READY;
      if (xfer) begin
        got_data.push_back(DATA_OUT); got_last.push_back(LAST);
        $display("[TB] beat %0d data=%0d last=%0b", got_data.size() - 1, DATA_OUT, LAST);
      end
      prev_stall = VALID && !READY; prev_data = DATA_OUT; prev_last = LAST;
      prev_xfer_last = xfer && LAST; prev_read = PIX_READ;
      if (PIX_READ) begin
        for (int i = 0; i < W; i++)
          CMP[i] = (conv_cyc < rise[i]) ? 1'b0 :
                   (conv_cyc == rise[i] || !glitch) ? 1'b1 : 1'($urandom);
        conv_cyc++;
      end else begin
        CMP = W'($urandom);
      end
      if (busy_start && PIX_EXPOSE && expose_cnt == 1) START = 1'b1;
      if (post > 0) begin
        post--;
        if (post == 0) fin = 1;
      end else if (DONE === 1'b1 && post < 0) begin
        if (chain) begin
          START = 1'b1; BIN2 = chain_bin2; EXPOSE_CYCLES = chain_exp; fin = 1;
        end else post = 3;
      end
    end
    if (!fin) timeout = 1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    tests_run++;
    if ({PIX_ERASE, PIX_EXPOSE, PIX_READ, COUNTER, DATA_OUT, VALID, LAST, BUSY, DONE} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %b required all zero",
               {PIX_ERASE, PIX_EXPOSE, PIX_READ, COUNTER, DATA_OUT, VALID, LAST, BUSY, DONE});
    end
    CMP = '1; READY = 1'b1;
    @(negedge CLK); RESET_N = 1'b1;
    repeat (5) @(negedge CLK);
    tests_run++;
    if (BUSY !== 1'b0 || VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_no_start busy=%b valid=%b required 0 0", BUSY, VALID);
    end
  endtask

  task automatic test_full_row();
    rise = '{3, 7, 11, 15}; glitch = 0; ready_mode = 0; busy_start = 0; chain = 0;
    build_model(0);
    run_frame(0, 16'd3, 0);
    tests_run++;
    if (timeout || got_data.size() != exp_data.size()) begin
      tests_failed++;
      $display("FAIL full_row_count got %0d beats (timeout=%0b) required %0d", got_data.size(), timeout, exp_data.size());
    end
    foreach (exp_data[k]) if (k < got_data.size()) begin
      tests_run++;
      if (got_data[k] !== exp_data[k] || got_last[k] !== (k == exp_data.size() - 1)) begin
        tests_failed++;
        $display("FAIL full_row_beat%0d got %0d/last=%0b required %0d/last=%0b", k, got_data[k], got_last[k], exp_data[k], k == exp_data.size() - 1);
      end
    end
    tests_run++;
    if (erase_cnt != EC || expose_cnt != 3 || read_cnt != 16 || counter_bad != 0) begin
      tests_failed++;
      $display("FAIL full_row_phases got erase=%0d expose=%0d read=%0d counter_bad=%0d required 4 3 16 0", erase_cnt, expose_cnt, read_cnt, counter_bad);
    end
    tests_run++;
    if (done_cnt != 1 || done_delay_bad != 0 || busy_done_bad != 0 || valid_late != 0) begin
      tests_failed++;
      $display("FAIL full_row_done got done=%0d delay_bad=%0d busy_bad=%0d valid_late=%0d required 1 0 0 0", done_cnt, done_delay_bad, busy_done_bad, valid_late);
    end
  endtask

  task automatic test_binning();
    rise = '{3, 7, 11, 15}; glitch = 0; ready_mode = 0; busy_start = 0; chain = 0;
    build_model(1);
    run_frame(1, 16'd2, 0);
    tests_run++;
    if (timeout || got_data.size() != 2) begin
      tests_failed++;
      $display("FAIL bin2_count got %0d beats (timeout=%0b) required 2", got_data.size(), timeout);
    end
    foreach (exp_data[k]) if (k < got_data.size()) begin
      tests_run++;
      if (got_data[k] !== exp_data[k] || got_last[k] !== (k == 1)) begin
        tests_failed++;
        $display("FAIL bin2_beat%0d got %0d/last=%0b required %0d/last=%0b", k, got_data[k], got_last[k], exp_data[k], k == 1);
      end
    end
  endtask

  task automatic test_never_and_glitch();
    rise = '{2, 5, 99, 9}; glitch = 1; ready_mode = 0; busy_start = 0; chain = 0;
    build_model(0);
    run_frame(0, 16'd1, 0);
    tests_run++;
    if (timeout || got_data.size() != W) begin
      tests_failed++;
      $display("FAIL never_rise_count got %0d beats required %0d", got_data.size(), W);
    end
    foreach (exp_data[k]) if (k < got_data.size()) begin
      tests_run++;
      if (got_data[k] !== exp_data[k]) begin
        tests_failed++;
        $display("FAIL never_rise_col%0d got %0d required %0d", k, got_data[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_ready_stall();
    rise = '{1, 4, 9, 13}; glitch = 0; ready_mode = 2; busy_start = 0; chain = 0;
    build_model(0);
    run_frame(0, 16'd2, 0);
    tests_run++;
    if (hold_bad != 0 || stall_used != 5) begin
      tests_failed++;
      $display("FAIL stall_hold got violations=%0d stalls=%0d required 0 5", hold_bad, stall_used);
    end
    tests_run++;
    if (timeout || got_data.size() != exp_data.size()) begin
      tests_failed++;
      $display("FAIL stall_count got %0d beats required %0d", got_data.size(), exp_data.size());
    end
    foreach (exp_data[k]) if (k < got_data.size()) begin
      tests_run++;
      if (got_data[k] !== exp_data[k] || got_last[k] !== (k == W - 1)) begin
        tests_failed++;
        $display("FAIL stall_beat%0d got %0d/last=%0b required %0d/last=%0b", k, got_data[k], got_last[k], exp_data[k], k == W - 1);
      end
    end
  endtask

  task automatic test_expose_zero();
    rise = '{0, 15, 6, 8}; glitch = 0; ready_mode = 0; busy_start = 1; chain = 0;
    build_model(0);
    run_frame(0, 16'd0, 0);
    busy_start = 0;
    tests_run++;
    if (erase_cnt != EC || expose_cnt != 1) begin
      tests_failed++;
      $display("FAIL expose_zero got erase=%0d expose=%0d required 4 1", erase_cnt, expose_cnt);
    end
    tests_run++;
    if (timeout || done_cnt != 1 || busy_after != 0 || got_data.size() != W) begin
      tests_failed++;
      $display("FAIL busy_start_ignored got done=%0d busy_after=%0d beats=%0d required 1 0 %0d", done_cnt, busy_after, got_data.size(), W);
    end
  endtask

  task automatic test_reset_mid_convert();
    bit found;
    int bad;
    found = 0; bad = 0;
    @(negedge CLK);
    START = 1'b1; BIN2 = 1'b0; EXPOSE_CYCLES = 16'd2; READY = 1'b1;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge CLK);
      START = 1'b0;
      CMP = PIX_READ ? '1 : '0;
      if (PIX_READ && COUNTER == B'(6)) found = 1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL abort_reach_counter6 got found=0 required 1");
    end
    #1 RESET_N = 1'b0;
    #1;
    tests_run++;
    if ({PIX_ERASE, PIX_EXPOSE, PIX_READ, COUNTER, DATA_OUT, VALID, LAST, BUSY, DONE} !== '0) begin
      tests_failed++;
      $display("FAIL abort_outputs got %b required all zero",
               {PIX_ERASE, PIX_EXPOSE, PIX_READ, COUNTER, DATA_OUT, VALID, LAST, BUSY, DONE});
    end
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (VALID !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL abort_no_beats got %0d active cycles required 0", bad);
    end
    rise = '{99, 10, 99, 12}; glitch = 0; ready_mode = 0; busy_start = 0; chain = 0;
    build_model(0);
    run_frame(0, 16'd1, 0);
    tests_run++;
    if (timeout || got_data.size() != W) begin
      tests_failed++;
      $display("FAIL after_abort_count got %0d beats required %0d", got_data.size(), W);
    end
    foreach (exp_data[k]) if (k < got_data.size()) begin
      tests_run++;
      if (got_data[k] !== exp_data[k]) begin
        tests_failed++;
        $display("FAIL after_abort_col%0d got %0d required %0d", k, got_data[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [B-1:0] first_exp [$];
    rise = '{4, 4, 12, 0}; glitch = 0; ready_mode = 0; busy_start = 0;
    chain = 1; chain_bin2 = 1; chain_exp = 16'd3;
    build_model(0);
    first_exp = exp_data;
    run_frame(0, 16'd1, 0);
    tests_run++;
    if (timeout || got_data.size() != first_exp.size() || got_data[got_data.size() - 1] !== first_exp[first_exp.size() - 1]) begin
      tests_failed++;
      $display("FAIL b2b_first got %0d beats (timeout=%0b) required %0d", got_data.size(), timeout, first_exp.size());
    end
    chain = 0;
    rise = '{1, 8, 30, 14};
    build_model(1);
    run_frame(1, 16'd3, 1);
    tests_run++;
    if (timeout || erase_cnt != EC || expose_cnt != 3 || got_data.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_second got erase=%0d expose=%0d beats=%0d timeout=%0b required 4 3 2 0", erase_cnt, expose_cnt, got_data.size(), timeout);
    end
    foreach (exp_data[k]) if (k < got_data.size()) begin
      tests_run++;
      if (got_data[k] !== exp_data[k]) begin
        tests_failed++;
        $display("FAIL b2b_second_beat%0d got %0d required %0d", k, got_data[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_random();
    bit bin2;
    int expo;
    for (int f = 0; f < 8; f++) begin
      foreach (rise[i]) rise[i] = $urandom_range(0, 20);
      glitch = 1'($urandom); ready_mode = 1; busy_start = 0; chain = 0;
      bin2 = 1'($urandom); expo = $urandom_range(0, 6);
      build_model(bin2);
      run_frame(bin2, 16'(expo), 0);
      tests_run++;
      if (timeout || got_data.size() != exp_data.size() || hold_bad != 0 || counter_bad != 0 ||
          expose_cnt != ((expo == 0) ? 1 : expo) || done_delay_bad != 0) begin
        tests_failed++;
        $display("FAIL random%0d_frame got beats=%0d hold=%0d cnt=%0d expose=%0d donebad=%0d required %0d 0 0 %0d 0",
                 f, got_data.size(), hold_bad, counter_bad, expose_cnt, done_delay_bad, exp_data.size(), (expo == 0) ? 1 : expo);
      end
      foreach (exp_data[k]) if (k < got_data.size()) begin
        tests_run++;
        if (got_data[k] !== exp_data[k] || got_last[k] !== (k == exp_data.size() - 1)) begin
          tests_failed++;
          $display("FAIL random%0d_beat%0d got %0d/last=%0b required %0d/last=%0b", f, k, got_data[k], got_last[k], exp_data[k], k == exp_data.size() - 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_row();
    test_binning();
    test_never_and_glitch();
    test_ready_stall();
    test_expose_zero();
    test_reset_mid_convert();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pixel_row_readout.md
PIXEL_ROW_READOUT -- requirements
Module: pixel_row_readout

Interface
REQ-001 SHALL have parameter WIDTH, default 4: pixel columns in the row; even, at least 2.
REQ-002 SHALL have parameter BITS, default 8: ramp-ADC resolution and conversion counter width.
REQ-003 SHALL have parameter ERASE_CYCLES, default 4: length of the erase phase in clock cycles.
REQ-004 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port START, input, 1: single-cycle pulse requesting one capture-and-readout frame.
REQ-007 SHALL have port BIN2, input, 1: mode select; 0 = full row, 1 = 2:1 horizontal binning.
REQ-008 SHALL have port EXPOSE_CYCLES, input, 16: exposure length in cycles.
REQ-009 SHALL have port CMP, input, WIDTH: per-column comparator outputs; high = ramp has crossed the pixel voltage.
REQ-010 SHALL have port PIX_ERASE, output, 1: pixel erase control.
REQ-011 SHALL have port PIX_EXPOSE, output, 1: pixel expose control.
REQ-012 SHALL have port PIX_READ, output, 1: pixel read/convert enable.
REQ-013 SHALL have port COUNTER, output, BITS: conversion count, drives the ramp DAC.
REQ-014 SHALL have port DATA_OUT, output, BITS: streamed pixel value.
REQ-015 SHALL have port VALID, output, 1: DATA_OUT holds a beat.
REQ-016 SHALL have port READY, input, 1: downstream accepts a beat.
REQ-017 SHALL have port LAST, output, 1: the current beat is the final beat of the frame.
REQ-018 SHALL have port BUSY, output, 1: high in every state except IDLE.
REQ-019 SHALL have port DONE, output, 1: one-cycle pulse at frame end.

Function
REQ-020 SHALL implement the FSM IDLE -> ERASE -> EXPOSE -> CONVERT -> READOUT -> IDLE.
REQ-021 SHALL, on START=1 in IDLE, sample BIN2 and EXPOSE_CYCLES into frame registers and enter ERASE on the next edge.
REQ-022 SHALL ignore START in every state other than IDLE.
REQ-023 SHALL hold PIX_ERASE=1 for exactly ERASE_CYCLES cycles in ERASE.
REQ-024 SHALL hold PIX_EXPOSE=1 for exactly EXPOSE_CYCLES cycles in EXPOSE; EXPOSE_CYCLES=0 SHALL be treated as 1.
REQ-025 SHALL hold PIX_READ=1 in CONVERT for exactly 2^BITS cycles, with COUNTER = 0, 1, ..., 2^BITS-1, one value per cycle; COUNTER SHALL be 0 outside CONVERT.
REQ-026 SHALL, in CONVERT, latch column i = COUNTER in the first cycle in which CMP[i]=1; later CMP[i] activity SHALL not change the latch.
REQ-027 SHALL latch 2^BITS-1 for any column whose CMP never rises during CONVERT.
REQ-028 SHALL treat CMP as already synchronous to CLK and SHALL ignore it outside CONVERT.
REQ-029 SHALL emit WIDTH beats in READOUT when BIN2=0: column 0 first, then ascending.
REQ-030 SHALL emit WIDTH/2 beats when BIN2=1: beat k = (col[2k] + col[2k+1]) >> 1, summed at BITS+1 bits, no overflow loss.
REQ-031 SHALL complete a transfer on an edge with VALID=1 and READY=1.
REQ-032 SHALL keep VALID, once asserted, asserted with DATA_OUT and LAST stable until the transfer completes.
REQ-033 SHALL assert VALID in the first READOUT cycle; the maximum rate SHALL be one beat per cycle.
REQ-034 SHALL assert LAST only with the final beat.
REQ-035 SHALL, after the LAST transfer, return to IDLE and pulse DONE for one cycle.
REQ-036 SHALL allow a START arriving in the cycle DONE is high to be accepted, because the FSM is then IDLE.

Reset
REQ-037 SHALL, on RESET_N=0, immediately return to IDLE from any state, including mid-CONVERT and mid-READOUT.
REQ-038 SHALL, on RESET_N=0, clear all column latches and frame registers.
REQ-039 SHALL drive every output to 0 while RESET_N=0, and no beat SHALL be emitted for the aborted frame.
REQ-040 SHALL require a fresh START after RESET_N deasserts.

Structure
REQ-041 SHALL place the FSM state enum and the default constants (WIDTH, BITS, ERASE_CYCLES) in the shared package used by the pixel-array blocks.
REQ-042 SHALL implement the per-column first-crossing latch as sub-module column_latch, instantiated WIDTH times by a generate loop.

Verification
REQ-043 SHALL cover: WIDTH=4, BITS=4, BIN2=0, CMP[i] rising at COUNTER=3, 7, 11, 15, READY=1 -> beats 3, 7, 11, 15; LAST on the 4th beat; DONE one cycle later.
REQ-044 SHALL cover: same stimulus with BIN2=1 -> two beats, 5 and 13; LAST on beat 2.
REQ-045 SHALL cover: CMP[2] never rises, CMP[0] toggles after its first rise at 2 -> column 2 = 15, column 0 = 2.
REQ-046 SHALL cover: READY=0 for 5 cycles at beat 1 -> VALID, DATA_OUT and LAST stable throughout; no beat lost or duplicated.
REQ-047 SHALL cover: EXPOSE_CYCLES=0, ERASE_CYCLES=4 -> PIX_ERASE high 4 cycles, PIX_EXPOSE high 1 cycle; START during BUSY ignored.
REQ-048 SHALL cover: RESET_N low at COUNTER=6 -> all outputs 0 immediately; the next START produces a clean frame with no stale latches.
